micro_prog_loader: RTL and testbench

Writes programs into the 13-bit instruction memory that the micro core fetches from. It is the writer side of the core's program-memory read port.
- Accepts a byte stream over a valid/ready handshake.
- Frames the stream into instruction words and writes them sequentially from address 0.
- Holds the core in reset while a load is in progress and releases it only after a frame with a valid checksum.

---
 rtl/micro_pkg.sv | 38 +++
 rtl/micro_prog_loader_if.sv | 21 ++
 rtl/micro_prog_loader.sv | 155 +++++++++++++++
 tb/tb_micro_prog_loader.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/micro_pkg.sv
// Shared definitions for the micro core and its program-memory loader.
package micro_pkg;

    localparam int unsigned INST_W = 13;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned BYTE_W = 8;

    localparam logic [1:0] OP_LOAD  = 2'd0;
    localparam logic [1:0] OP_STORE = 2'd1;
    localparam logic [1:0] OP_ADD   = 2'd2;
    localparam logic [1:0] OP_SUB   = 2'd3;

    localparam int unsigned OP_MSB       = 12;
    localparam int unsigned OP_LSB       = 11;
    localparam int unsigned PC_W_BIT     = 10;
    localparam int unsigned COND_BIT     = 9;
    localparam int unsigned MEM_LIT_BIT  = 8;
    localparam int unsigned ADDR_LIT_MSB = 7;
    localparam int unsigned ADDR_LIT_LSB = 0;

    localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CSUM, DONE, ERR} loader_state_e;

    typedef struct packed {
        logic [1:0] op;
        logic       pc_w_;
        logic       cond;
        logic       mem_lit;
        logic [7:0] addr_lit;
    } inst_t;

    // Instruction word from the low five bits of HI and the full LO byte.
    function automatic inst_t pack_word(input logic [4:0] hi, input logic [7:0] lo);
        return inst_t'({hi, lo});
    endfunction

endpackage

// File: rtl/micro_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
interface micro_prog_loader_if;

    logic                                byte_valid;
    logic [micro_pkg::BYTE_W-1:0]        byte_data;
    logic                                byte_ready;
    logic                                mem_we;
    logic [micro_pkg::ADDR_W-1:0]        mem_addr;
    micro_pkg::inst_t                    mem_wdata;

    modport master (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/micro_prog_loader.sv
// Frames a byte stream into instruction words, writes them from address 0 and
// holds the core in reset until a checksum-valid frame lands. MICRO_LOADER_STRICT_EN rejects HI bytes with bits[7:5] set.
module micro_prog_loader
    import micro_pkg::*;
#(
    parameter int unsigned      DEPTH  = 32,
    parameter logic [7:0]       HEADER = HEADER_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    micro_prog_loader_if.master bus,
    output logic                cpu_reset,
    output logic                done,
    output logic                err
);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_COUNT = 3'(COUNT);
    localparam logic [2:0] S_HI    = 3'(HI);
    localparam logic [2:0] S_LO    = 3'(LO);
    localparam logic [2:0] S_CSUM  = 3'(CSUM);
    localparam logic [2:0] S_DONE  = 3'(DONE);
    localparam logic [2:0] S_ERR   = 3'(ERR);

    localparam logic [7:0] DEPTH_B = 8'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic [7:0]        csum_q, csum_d;
    logic [7:0]        idx_q, idx_d;
    logic [4:0]        hi_q, hi_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    inst_t             mem_wdata_d;
    logic              cpu_reset_d, done_d, err_d;
    logic              is_hdr;
    logic [7:0]        csum_sum;

    assign bus.byte_ready = 1'b1;
    assign is_hdr         = (bus.byte_data == HEADER);
    assign csum_sum       = csum_q + bus.byte_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            csum_q        <= '0;
            idx_q         <= '0;
            hi_q          <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            cpu_reset     <= 1'b1;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            csum_q        <= csum_d;
            idx_q         <= idx_d;
            hi_q          <= hi_d;
            bus.mem_we    <= mem_we_d;
            bus.mem_addr  <= mem_addr_d;
            bus.mem_wdata <= mem_wdata_d;
            cpu_reset     <= cpu_reset_d;
            done          <= done_d;
            err           <= err_d;
        end
    end

    // Next-state and next-output logic; nothing moves without a byte transfer.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = bus.mem_addr;
        mem_wdata_d = bus.mem_wdata;
        cpu_reset_d = cpu_reset;
        done_d      = done;
        err_d       = err;

        if (bus.byte_valid) begin
            case (state_q)
                S_IDLE: begin
                    if (is_hdr) begin
                        state_d = S_COUNT;
                        csum_d  = '0;
                    end
                end
                S_COUNT: begin
                    if (bus.byte_data == 8'd0 || bus.byte_data > DEPTH_B) begin
                        state_d     = S_ERR;
                        err_d       = 1'b1;
                        done_d      = 1'b0;
                        cpu_reset_d = 1'b1;
                    end else begin
                        state_d = S_HI;
                        count_d = bus.byte_data;
                        csum_d  = bus.byte_data;
                        idx_d   = '0;
                    end
                end
                S_HI: begin
                    state_d = S_LO;
                    hi_d    = bus.byte_data[4:0];
                    csum_d  = csum_sum;
`ifdef MICRO_LOADER_STRICT_EN
                    if (bus.byte_data[7:5] != 3'd0) begin
                        state_d     = S_ERR;
                        err_d       = 1'b1;
                        done_d      = 1'b0;
                        cpu_reset_d = 1'b1;
                    end
`endif
                end
                S_LO: begin
                    csum_d      = csum_sum;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = idx_q;
                    mem_wdata_d = pack_word(hi_q, bus.byte_data);
                    idx_d       = idx_q + 8'd1;
                    state_d     = (idx_q + 8'd1 == count_q) ? S_CSUM : S_HI;
                end
                S_CSUM: begin
                    csum_d = csum_sum;
                    if (csum_sum == 8'd0) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        err_d       = 1'b0;
                        cpu_reset_d = 1'b0;
                    end else begin
                        state_d     = S_ERR;
                        err_d       = 1'b1;
                        done_d      = 1'b0;
                        cpu_reset_d = 1'b1;
                    end
                end
                S_DONE, S_ERR: begin
                    if (is_hdr) begin
                        state_d     = S_COUNT;
                        csum_d      = '0;
                        done_d      = 1'b0;
                        err_d       = 1'b0;
                        cpu_reset_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_micro_prog_loader.sv
// Self-checking bench for micro_prog_loader: vector table, hand sequences and
// randomized frames checked against a frame-level model.
module tb_micro_prog_loader;
    import micro_pkg::*;

    localparam int unsigned DEPTH = 32;
`ifdef MICRO_LOADER_STRICT_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic cpu_reset, done, err;

    micro_prog_loader_if bus();

    micro_prog_loader #(.DEPTH(DEPTH), .HEADER(8'hA5)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  addr;
        logic [12:0] data;
    } wr_t;

    typedef struct {
        int          nb;
        logic [7:0]  b [8];
        int          nw;
        logic [12:0] w [2];
        logic        exp_done;
        logic        exp_err;
    } vec_t;

    wr_t  wq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(negedge clk)
        if (bus.mem_we === 1'b1) wq.push_back('{bus.mem_addr, 13'(bus.mem_wdata)});

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        @(posedge clk);
        #1;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'hA5;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wq.delete();
    endtask

    task automatic check_writes(input string name, input wr_t exp[$]);
        check({name, "_nwrites"}, 32'(wq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < wq.size(); i++) begin
            check($sformatf("%s_addr%0d", name, i), 32'(wq[i].addr), 32'(exp[i].addr));
            check($sformatf("%s_data%0d", name, i), 32'(wq[i].data), 32'(exp[i].data));
        end
    endtask

    task automatic check_flags(input string name, input logic e_done, input logic e_err);
        check({name, "_done"}, 32'(done), 32'(e_done));
        check({name, "_err"}, 32'(err), 32'(e_err));
        check({name, "_cpu_reset"}, 32'(cpu_reset), 32'(!e_done));
    endtask

    // Frame-level model: expectations follow from how the frame was built.
    task automatic run_random_frame(input int it);
        logic [7:0] bytes[$];
        wr_t        exp[$];
        logic [7:0] b, hi, lo, csum;
        int         n, sum, bad_pair;
        logic       e_done, e_err, stopped;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h5A;
            bytes.push_back(b);
        end
        bytes.push_back(8'hA5);
        if (it != 0 && $urandom_range(0, 7) == 0)
            n = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(DEPTH + 1, 255));
        else
            n = (it == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
        bytes.push_back(8'(n));
        e_done = 1'b0;
        e_err  = 1'b1;
        if (n >= 1 && n <= DEPTH) begin
            sum      = n;
            stopped  = 1'b0;
            bad_pair = (STRICT && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            for (int i = 0; i < n; i++) begin
                hi = 8'($urandom);
                lo = 8'($urandom);
                if (STRICT) hi[7:5] = (i == bad_pair) ? 3'($urandom_range(1, 7)) : 3'd0;
                bytes.push_back(hi);
                if (STRICT && hi[7:5] != 3'd0) begin
                    stopped = 1'b1;
                    break;
                end
                bytes.push_back(lo);
                sum += int'(hi) + int'(lo);
                exp.push_back('{8'(i), {hi[4:0], lo}});
            end
            if (!stopped) begin
                csum = 8'(-sum);
                if ($urandom_range(0, 3) == 0) csum = csum + 8'($urandom_range(1, 255));
                bytes.push_back(csum);
                e_done = (8'(sum + int'(csum)) == 8'd0);
                e_err  = !e_done;
            end
        end
        foreach (bytes[i]) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send_byte(bytes[i]);
        end
        repeat (2) @(negedge clk);
        check_writes($sformatf("rnd%0d", it), exp);
        check_flags($sformatf("rnd%0d", it), e_done, e_err);
        wq.delete();
    endtask

    initial begin
        vec_t vt[$];
        vec_t v;
        wr_t  exp[$];

        reset          = 1'b1;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_flags("reset", 1'b0, 1'b0);
        check("reset_we", 32'(bus.mem_we), 32'd0);
        check("reset_addr", 32'(bus.mem_addr), 32'd0);
        check("reset_wdata", 32'(bus.mem_wdata), 32'd0);
        check("ready", 32'(bus.byte_ready), 32'd1);
        reset = 1'b0;

        v = '{7, '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h19, 8'h01, 8'hE3, 8'h00}, 2, '{13'h0100, 13'h1901}, 1'b1, 1'b0};
        vt.push_back(v);
        v = '{7, '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h19, 8'h01, 8'hE4, 8'h00}, 2, '{13'h0100, 13'h1901}, 1'b0, 1'b1};
        vt.push_back(v);
        v = '{2, '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, '{13'h0, 13'h0}, 1'b0, 1'b1};
        vt.push_back(v);
        v = '{2, '{8'hA5, 8'h21, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, '{13'h0, 13'h0}, 1'b0, 1'b1};
        vt.push_back(v);
        v = '{2, '{8'hA5, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, '{13'h0, 13'h0}, 1'b0, 1'b0};
        vt.push_back(v);
        v = '{7, '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h03, 8'h04, 8'hF8, 8'h00}, 1, '{13'h0304, 13'h0}, 1'b1, 1'b0};
        vt.push_back(v);
        v = '{2, '{8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 0, '{13'h0, 13'h0}, 1'b0, 1'b0};
        vt.push_back(v);
        if (STRICT)
            v = '{5, '{8'hA5, 8'h01, 8'h21, 8'h00, 8'hDE, 8'h00, 8'h00, 8'h00}, 0, '{13'h0, 13'h0}, 1'b0, 1'b1};
        else
            v = '{5, '{8'hA5, 8'h01, 8'h21, 8'h00, 8'hDE, 8'h00, 8'h00, 8'h00}, 1, '{13'h0100, 13'h0}, 1'b1, 1'b0};
        vt.push_back(v);

        for (int k = 0; k < vt.size(); k++) begin
            do_reset();
            for (int i = 0; i < vt[k].nb; i++) send_byte(vt[k].b[i]);
            repeat (2) @(negedge clk);
            exp.delete();
            for (int i = 0; i < vt[k].nw; i++) exp.push_back('{8'(i), vt[k].w[i]});
            check_writes($sformatf("vec%0d", k), exp);
            check_flags($sformatf("vec%0d", k), vt[k].exp_done, vt[k].exp_err);
        end

        // Write latency and cpu_reset release timing.
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
        check("lat_we0", 32'(bus.mem_we), 32'd1);
        check("lat_addr0", 32'(bus.mem_addr), 32'd0);
        check("lat_data0", 32'(bus.mem_wdata), 32'h0100);
        send_byte(8'h19);
        check("lat_hi_nowe", 32'(bus.mem_we), 32'd0);
        send_byte(8'h01);
        check("lat_we1", 32'(bus.mem_we), 32'd1);
        check("lat_addr1", 32'(bus.mem_addr), 32'd1);
        check("lat_data1", 32'(bus.mem_wdata), 32'h1901);
        check("lat_cpu_reset_held", 32'(cpu_reset), 32'd1);
        send_byte(8'hE3);
        check("lat_cpu_reset_rel", 32'(cpu_reset), 32'd0);
        check("lat_done", 32'(done), 32'd1);

        // Junk ignored in DONE, header restarts.
        send_byte(8'h12);
        check("restart_junk_done", 32'(done), 32'd1);
        send_byte(8'hA5);
        check_flags("restart_hdr", 1'b0, 1'b0);
        wq.delete();
        send_byte(8'h01); send_byte(8'h03); send_byte(8'h04); send_byte(8'hF8);
        repeat (2) @(negedge clk);
        exp.delete();
        exp.push_back('{8'd0, 13'h0304});
        check_writes("restart", exp);
        check_flags("restart", 1'b1, 1'b0);

        // Error then restart without reset.
        send_byte(8'hA5); send_byte(8'h00);
        check_flags("err_n0", 1'b0, 1'b1);
        send_byte(8'h77);
        check("err_junk", 32'(err), 32'd1);
        wq.delete();
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03); send_byte(8'h04); send_byte(8'hF8);
        repeat (2) @(negedge clk);
        check_writes("err_restart", exp);
        check_flags("err_restart", 1'b1, 1'b0);

        // Asynchronous reset mid-frame, then a clean reload from address 0.
        do_reset();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
        reset = 1'b1;
        #1;
        check("midrst_we", 32'(bus.mem_we), 32'd0);
        check("midrst_addr", 32'(bus.mem_addr), 32'd0);
        check_flags("midrst", 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        wq.delete();
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h19); send_byte(8'h01); send_byte(8'hE3);
        repeat (2) @(negedge clk);
        exp.delete();
        exp.push_back('{8'd0, 13'h0100});
        exp.push_back('{8'd1, 13'h1901});
        check_writes("midrst_reload", exp);
        check_flags("midrst_reload", 1'b1, 1'b0);

        do_reset();
        for (int it = 0; it < 40; it++) run_random_frame(it);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
